incident_sequencer: RTL and testbench
=====================================

Name: incident_sequencer

Overview:
- Sits directly downstream of the collision detector, ambulance-parameter and ambulance-position stages.
- Consumes is_collision, the ambulance motion parameters and the live ambulance position.
- Runs a second-granularity incident lifecycle: confirm, dispatch, on-scene dwell, scene clear, cooldown.
- Drives car-reset, siren, status and score logic in the top level.

Parameters:
- CONFIRM_CYCLES, default 4: consecutive clk edges with is_collision=1 required to confirm an incident (range 1..15).
- DWELL_SECS, default 3: one_hz_enable ticks the ambulance stays on scene.
- TIMEOUT_SECS, default 10: ticks allowed in DISPATCH before a forced arrival.
- COOLDOWN_SECS, default 2: ticks after an incident during which new collisions are ignored.
- CSPEED, default 8: ambulance step per tick; must equal the motion stage's value.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- one_hz_enable  in  1  single-cycle tick strobe
- is_collision  in  1  from collision detector
- ambulance_move_dir  in  2  shared MOVE_LEFT/MOVE_RIGHT/MOVE_UP/MOVE_DOWN encodings from params.v
- ambulance_dest_x  in  11  destination x
- ambulance_dest_y  in  10  destination y
- ambulance_leftx  in  11  live ambulance left x
- ambulance_width  in  11  live ambulance width
- ambulance_topy  in  10  live ambulance top y
- ambulance_height  in  10  live ambulance height
- fsm_state  out  3  IDLE=0, ALERT=1, DISPATCH=2, ON_SCENE=3, CLEAR=4, COOLDOWN=5
- amb_visible  out  1  high in DISPATCH and ON_SCENE
- incident_active  out  1  high in DISPATCH, ON_SCENE and CLEAR
- siren_on  out  1  flashing siren
- clear_scene  out  1  one-cycle pulse commanding the car-reset logic
- timeout_flag  out  1  last arrival was forced by timeout
- incident_count  out  8  confirmed incidents, saturating

Behaviour:
Reset and general rules:
- One clock; reset is synchronous and active-high.
- Reset has priority over everything. On the following edge: state IDLE, all counters 0, and every output 0 (incident_count and timeout_flag included).
- All outputs are registered.
- sec_cnt (4 bits) clears on every state change.
- In a tick-counted state, a cycle with one_hz_enable=1 either transitions (when sec_cnt==N-1) or increments sec_cnt. The transition therefore occurs on the Nth tick after entry. A tick coinciding with the entry edge is not counted.

IDLE:
- is_collision=1 -> ALERT, conf_cnt=1.
- If CONFIRM_CYCLES==1, go directly to DISPATCH instead.

ALERT:
- is_collision=0 -> IDLE, conf_cnt=0.
- Otherwise conf_cnt++. When is_collision has been sampled high on CONFIRM_CYCLES consecutive edges -> DISPATCH.
- With the default of 4, DISPATCH is reached on the 4th high edge.

Entry to DISPATCH:
- Latch ambulance_move_dir into dir_q.
- incident_count++, saturating at 255.
- siren_on=1, timeout_flag=0.

DISPATCH:
- siren_on toggles on each tick.
- Arrival is evaluated every cycle using 12-bit zero-extended arithmetic, so there is no wrap. Arrival conditions by dir_q:
  - LEFT: leftx <= dest_x + CSPEED.
  - RIGHT: leftx + CSPEED >= dest_x - width; arrived if dest_x < width.
  - UP: topy <= dest_y + CSPEED.
  - DOWN: topy + CSPEED >= dest_y - height; arrived if dest_y < height.
- Arrival -> ON_SCENE.
- If TIMEOUT_SECS ticks elapse without arrival -> ON_SCENE with timeout_flag=1.
- If arrival and the timeout tick occur in the same cycle, arrival wins and timeout_flag stays 0.

ON_SCENE:
- siren_on keeps toggling per tick.
- After DWELL_SECS ticks -> CLEAR. clear_scene=1 for exactly the entry cycle into CLEAR; siren_on=0.

CLEAR:
- Wait until is_collision=0 -> COOLDOWN. No timeout.

Abort:
- is_collision=0 in DISPATCH or ON_SCENE -> COOLDOWN immediately.
- No clear_scene pulse; siren_on=0.
- Abort has priority over arrival, timeout and dwell completion in the same cycle.

COOLDOWN:
- is_collision is ignored.
- After COOLDOWN_SECS ticks -> IDLE.
- If is_collision is still 1 on that edge, IDLE takes the ALERT branch on the next edge. There is no same-edge shortcut.

Other:
- ambulance_move_dir changes after DISPATCH entry are ignored until the next incident.
- timeout_flag holds its value until the next DISPATCH entry or reset.

Test Plan:
1. Glitch rejection: is_collision high for 3 edges then low -> ALERT then IDLE; incident_count=0; amb_visible never asserts.
2. Nominal MOVE_LEFT flow:
   - Setup: dest_x=300; confirm 4 edges; leftx=500.
   - leftx=500 -> DISPATCH holds.
   - leftx=308 -> ON_SCENE on the next edge.
   - 3 ticks -> CLEAR, with clear_scene high exactly one cycle.
   - Drop is_collision -> COOLDOWN; 2 ticks -> IDLE.
   - Final: incident_count=1, timeout_flag=0.
3. Timeout: MOVE_UP, dest_y=200, topy held at 668 -> after the 10th tick, ON_SCENE with timeout_flag=1; siren_on toggled 10 times in DISPATCH.
4. MOVE_DOWN boundary: dest_y=300, height=100. topy=191 (199<200) -> stays in DISPATCH; topy=192 -> ON_SCENE.
5. Abort: is_collision falls on the same cycle as the 3rd ON_SCENE tick -> COOLDOWN, clear_scene never pulses, siren_on=0.
6. Reset and saturation:
   - Reset asserted mid-ON_SCENE -> all outputs 0 and state IDLE on the next edge.
   - Separately, 256 complete incidents -> incident_count=255 and remains 255.

Source files
------------

// File: rtl/incident_sequencer.sv
// Incident lifecycle sequencer: confirm -> dispatch -> on-scene dwell -> clear -> cooldown.
// Timing is in one_hz_enable ticks, except confirmation, which counts clock edges.
//
// Ports:
//   clk, reset                     system clock, synchronous active-high reset
//   one_hz_enable                  single-cycle tick strobe
//   is_collision                   collision detector output
//   ambulance_move_dir             ambulance heading, latched on dispatch
//   ambulance_dest_x/_y            ambulance destination
//   ambulance_leftx/_width         live ambulance horizontal extent
//   ambulance_topy/_height         live ambulance vertical extent
//   fsm_state                      IDLE=0 ALERT=1 DISPATCH=2 ON_SCENE=3 CLEAR=4 COOLDOWN=5
//   amb_visible, incident_active   state decodes (registered)
//   siren_on                       flashing siren
//   clear_scene                    one-cycle pulse on entry to CLEAR
//   timeout_flag                   last arrival was forced by timeout
//   incident_count                 confirmed incidents, saturating at 255
module incident_sequencer #(
  parameter int unsigned CONFIRM_CYCLES = 4,
  parameter int unsigned DWELL_SECS     = 3,
  parameter int unsigned TIMEOUT_SECS   = 10,
  parameter int unsigned COOLDOWN_SECS  = 2,
  parameter int unsigned CSPEED         = 8,
  parameter logic [1:0]  MOVE_LEFT      = 2'd0,
  parameter logic [1:0]  MOVE_RIGHT     = 2'd1,
  parameter logic [1:0]  MOVE_UP        = 2'd2,
  parameter logic [1:0]  MOVE_DOWN      = 2'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        one_hz_enable,
  input  logic        is_collision,
  input  logic [1:0]  ambulance_move_dir,
  input  logic [10:0] ambulance_dest_x,
  input  logic [9:0]  ambulance_dest_y,
  input  logic [10:0] ambulance_leftx,
  input  logic [10:0] ambulance_width,
  input  logic [9:0]  ambulance_topy,
  input  logic [9:0]  ambulance_height,
  output logic [2:0]  fsm_state,
  output logic        amb_visible,
  output logic        incident_active,
  output logic        siren_on,
  output logic        clear_scene,
  output logic        timeout_flag,
  output logic [7:0]  incident_count
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StAlert    = 3'd1,
    StDispatch = 3'd2,
    StOnScene  = 3'd3,
    StClear    = 3'd4,
    StCooldown = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  sec_cnt_q, sec_cnt_d;
  logic [3:0]  conf_cnt_q, conf_cnt_d;
  logic [1:0]  dir_q, dir_d;
  logic [7:0]  count_q, count_d;
  logic        siren_q, siren_d;
  logic        clear_q, clear_d;
  logic        timeout_q, timeout_d;
  logic        visible_q, visible_d;
  logic        active_q, active_d;
  logic        dispatch_entry;
  logic        arrived;

  // 12-bit zero-extended operands so sums and differences never wrap.
  logic [11:0] leftx_w, width_w, dest_x_w, topy_w, height_w, dest_y_w, cspeed_w;
  assign leftx_w  = {1'b0, ambulance_leftx};
  assign width_w  = {1'b0, ambulance_width};
  assign dest_x_w = {1'b0, ambulance_dest_x};
  assign topy_w   = {2'b0, ambulance_topy};
  assign height_w = {2'b0, ambulance_height};
  assign dest_y_w = {2'b0, ambulance_dest_y};
  assign cspeed_w = 12'(CSPEED);

  // Arrival within one step of the destination; a destination closer than the ambulance
  // size on the trailing side counts as already reached.
  always_comb begin
    arrived = 1'b0;
    case (dir_q)
      MOVE_LEFT:  arrived = leftx_w <= dest_x_w + cspeed_w;
      MOVE_RIGHT: arrived = (dest_x_w < width_w) || (leftx_w + cspeed_w >= dest_x_w - width_w);
      MOVE_UP:    arrived = topy_w <= dest_y_w + cspeed_w;
      MOVE_DOWN:  arrived = (dest_y_w < height_w) || (topy_w + cspeed_w >= dest_y_w - height_w);
      default:    arrived = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    sec_cnt_d      = sec_cnt_q;
    conf_cnt_d     = conf_cnt_q;
    dir_d          = dir_q;
    count_d        = count_q;
    siren_d        = siren_q;
    clear_d        = 1'b0;
    timeout_d      = timeout_q;
    dispatch_entry = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (is_collision) begin
          if (CONFIRM_CYCLES == 1) begin
            dispatch_entry = 1'b1;
          end else begin
            state_d    = StAlert;
            conf_cnt_d = 4'd1;
          end
        end
      end
      StAlert: begin
        if (!is_collision) begin
          state_d    = StIdle;
          conf_cnt_d = 4'd0;
        end else if (4'(conf_cnt_q + 4'd1) == 4'(CONFIRM_CYCLES)) begin
          dispatch_entry = 1'b1;
        end else begin
          conf_cnt_d = conf_cnt_q + 4'd1;
        end
      end
      StDispatch: begin
        if (!is_collision) begin
          state_d = StCooldown;
          siren_d = 1'b0;
        end else begin
          if (one_hz_enable) begin
            siren_d   = ~siren_q;
            sec_cnt_d = sec_cnt_q + 4'd1;
          end
          // Arrival beats a coincident timeout, leaving timeout_flag clear.
          if (arrived) begin
            state_d = StOnScene;
          end else if (one_hz_enable && sec_cnt_q == 4'(TIMEOUT_SECS - 1)) begin
            state_d   = StOnScene;
            timeout_d = 1'b1;
          end
        end
      end
      StOnScene: begin
        if (!is_collision) begin
          state_d = StCooldown;
          siren_d = 1'b0;
        end else if (one_hz_enable) begin
          if (sec_cnt_q == 4'(DWELL_SECS - 1)) begin
            state_d = StClear;
            clear_d = 1'b1;
            siren_d = 1'b0;
          end else begin
            sec_cnt_d = sec_cnt_q + 4'd1;
            siren_d   = ~siren_q;
          end
        end
      end
      StClear: begin
        if (!is_collision) state_d = StCooldown;
      end
      StCooldown: begin
        if (one_hz_enable) begin
          if (sec_cnt_q == 4'(COOLDOWN_SECS - 1)) state_d = StIdle;
          else sec_cnt_d = sec_cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (dispatch_entry) begin
      state_d    = StDispatch;
      conf_cnt_d = 4'd0;
      dir_d      = ambulance_move_dir;
      count_d    = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
      siren_d    = 1'b1;
      timeout_d  = 1'b0;
    end

    if (state_d != state_q) sec_cnt_d = 4'd0;

    visible_d = (state_d == StDispatch) || (state_d == StOnScene);
    active_d  = visible_d || (state_d == StClear);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      sec_cnt_q  <= 4'd0;
      conf_cnt_q <= 4'd0;
      dir_q      <= 2'd0;
      count_q    <= 8'd0;
      siren_q    <= 1'b0;
      clear_q    <= 1'b0;
      timeout_q  <= 1'b0;
      visible_q  <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_cnt_q  <= sec_cnt_d;
      conf_cnt_q <= conf_cnt_d;
      dir_q      <= dir_d;
      count_q    <= count_d;
      siren_q    <= siren_d;
      clear_q    <= clear_d;
      timeout_q  <= timeout_d;
      visible_q  <= visible_d;
      active_q   <= active_d;
    end
  end

  assign fsm_state       = state_q;
  assign amb_visible     = visible_q;
  assign incident_active = active_q;
  assign siren_on        = siren_q;
  assign clear_scene     = clear_q;
  assign timeout_flag    = timeout_q;
  assign incident_count  = count_q;

endmodule

// File: tb/tb_incident_sequencer.sv
// Self-checking bench for incident_sequencer: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_incident_sequencer;
  localparam int CONF = 4, DWELL = 3, TMO = 10, COOL = 2, CSP = 8;
  localparam int ML = 0, MR = 1, MU = 2, MD = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        one_hz_enable = 1'b0;
  logic        is_collision = 1'b0;
  logic [1:0]  ambulance_move_dir = 2'd0;
  logic [10:0] ambulance_dest_x = 11'd0;
  logic [9:0]  ambulance_dest_y = 10'd0;
  logic [10:0] ambulance_leftx = 11'd0;
  logic [10:0] ambulance_width = 11'd0;
  logic [9:0]  ambulance_topy = 10'd0;
  logic [9:0]  ambulance_height = 10'd0;
  logic [2:0]  fsm_state;
  logic        amb_visible, incident_active, siren_on, clear_scene, timeout_flag;
  logic [7:0]  incident_count;

  incident_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .one_hz_enable      (one_hz_enable),
    .is_collision       (is_collision),
    .ambulance_move_dir (ambulance_move_dir),
    .ambulance_dest_x   (ambulance_dest_x),
    .ambulance_dest_y   (ambulance_dest_y),
    .ambulance_leftx    (ambulance_leftx),
    .ambulance_width    (ambulance_width),
    .ambulance_topy     (ambulance_topy),
    .ambulance_height   (ambulance_height),
    .fsm_state          (fsm_state),
    .amb_visible        (amb_visible),
    .incident_active    (incident_active),
    .siren_on           (siren_on),
    .clear_scene        (clear_scene),
    .timeout_flag       (timeout_flag),
    .incident_count     (incident_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Phases: 0 idle, 1 confirming, 2 dispatched, 3 on scene, 4 clearing, 5 cooldown.
  int m_state = 0, m_prev = 0, m_streak = 0, m_ticks = 0, m_dir = 0, m_count = 0;
  bit m_siren = 0, m_clear = 0, m_tmo = 0;

  function automatic bit reached(input int dir);
    int lx = int'(ambulance_leftx), w = int'(ambulance_width), dx = int'(ambulance_dest_x);
    int ty = int'(ambulance_topy), h = int'(ambulance_height), dy = int'(ambulance_dest_y);
    case (dir)
      ML:      return lx <= dx + CSP;
      MR:      return dx < w || lx + CSP >= dx - w;
      MU:      return ty <= dy + CSP;
      default: return dy < h || ty + CSP >= dy - h;
    endcase
  endfunction

  function automatic void start_dispatch();
    m_state  = 2;
    m_streak = 0;
    m_dir    = int'(ambulance_move_dir);
    m_count  = (m_count < 255) ? m_count + 1 : 255;
    m_siren  = 1;
    m_tmo    = 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_state = 0; m_streak = 0; m_ticks = 0; m_dir = 0; m_count = 0;
      m_siren = 0; m_clear = 0; m_tmo = 0;
    end else begin
      m_prev  = m_state;
      m_clear = 0;
      case (m_state)
        0: if (is_collision) begin
          m_streak = 1;
          if (m_streak >= CONF) start_dispatch(); else m_state = 1;
        end
        1: if (!is_collision) begin
          m_state = 0; m_streak = 0;
        end else begin
          m_streak++;
          if (m_streak >= CONF) start_dispatch();
        end
        2: if (!is_collision) begin
          m_state = 5; m_siren = 0;
        end else begin
          if (one_hz_enable) begin m_ticks++; m_siren = !m_siren; end
          if (reached(m_dir)) m_state = 3;
          else if (m_ticks >= TMO) begin m_state = 3; m_tmo = 1; end
        end
        3: if (!is_collision) begin
          m_state = 5; m_siren = 0;
        end else if (one_hz_enable) begin
          m_ticks++;
          if (m_ticks >= DWELL) begin m_state = 4; m_clear = 1; m_siren = 0; end
          else m_siren = !m_siren;
        end
        4: if (!is_collision) m_state = 5;
        default: if (one_hz_enable) begin
          m_ticks++;
          if (m_ticks >= COOL) m_state = 0;
        end
      endcase
      if (m_state != m_prev) m_ticks = 0;
    end
  end

  // Single compare process against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", int'(fsm_state), m_state);
      chk("amb_visible", int'(amb_visible), int'(m_state == 2 || m_state == 3));
      chk("incident_active", int'(incident_active), int'(m_state >= 2 && m_state <= 4));
      chk("siren_on", int'(siren_on), int'(m_siren));
      chk("clear_scene", int'(clear_scene), int'(m_clear));
      chk("timeout_flag", int'(timeout_flag), int'(m_tmo));
      chk("incident_count", int'(incident_count), m_count);
    end
  end

  // ---------------- stimulus helpers ----------------
  bit vis_seen, clear_seen;
  int toggles, prev_state, prev_siren;

  task automatic edge_(input bit col, input bit tick);
    is_collision  = col;
    one_hz_enable = tick;
    @(posedge clk);
    #1;
    if (amb_visible) vis_seen = 1;
    if (clear_scene) clear_seen = 1;
    if (prev_state == 2 && int'(siren_on) != prev_siren) toggles++;
    prev_state = int'(fsm_state);
    prev_siren = int'(siren_on);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    edge_(0, 0);
    reset = 1'b0;
    vis_seen = 0; clear_seen = 0; toggles = 0;
  endtask

  task automatic confirm();
    repeat (CONF) edge_(1, 0);
  endtask

  initial begin
    do_reset();
    edge_(0, 0);
    chk_en = 1'b1;
    chk("reset_state", int'(fsm_state), 0);
    chk("reset_count", int'(incident_count), 0);

    // Glitch rejection.
    do_reset();
    repeat (3) edge_(1, 0);
    chk("glitch_alert", int'(fsm_state), 1);
    edge_(0, 0);
    chk("glitch_idle", int'(fsm_state), 0);
    chk("glitch_count", int'(incident_count), 0);
    chk("glitch_vis", int'(vis_seen), 0);

    // Nominal MOVE_LEFT flow.
    do_reset();
    ambulance_move_dir = 2'(ML); ambulance_dest_x = 11'd300; ambulance_leftx = 11'd500;
    ambulance_width = 11'd40;
    confirm();
    chk("left_dispatch", int'(fsm_state), 2);
    repeat (2) edge_(1, 0);
    chk("left_hold", int'(fsm_state), 2);
    ambulance_leftx = 11'd308;
    edge_(1, 0);
    chk("left_arrive", int'(fsm_state), 3);
    repeat (3) edge_(1, 1);
    chk("left_clear", int'(fsm_state), 4);
    chk("left_clear_pulse", int'(clear_scene), 1);
    edge_(1, 0);
    chk("left_pulse_once", int'(clear_scene), 0);
    edge_(0, 0);
    chk("left_cooldown", int'(fsm_state), 5);
    repeat (2) edge_(0, 1);
    chk("left_idle", int'(fsm_state), 0);
    chk("left_count", int'(incident_count), 1);
    chk("left_tmo", int'(timeout_flag), 0);

    // Timeout with MOVE_UP, ticks every other cycle.
    do_reset();
    ambulance_move_dir = 2'(MU); ambulance_dest_y = 10'd200; ambulance_topy = 10'd668;
    confirm();
    toggles = 0;
    for (int i = 0; i < 40 && fsm_state == 3'd2; i++) edge_(1, bit'(i % 2));
    chk("tmo_state", int'(fsm_state), 3);
    chk("tmo_flag", int'(timeout_flag), 1);
    chk("tmo_toggles", toggles, 10);

    // MOVE_DOWN boundary.
    do_reset();
    ambulance_move_dir = 2'(MD); ambulance_dest_y = 10'd300; ambulance_height = 10'd100;
    ambulance_topy = 10'd191;
    confirm();
    repeat (3) edge_(1, 0);
    chk("down_hold", int'(fsm_state), 2);
    ambulance_topy = 10'd192;
    edge_(1, 0);
    chk("down_arrive", int'(fsm_state), 3);

    // Abort on the third on-scene tick.
    do_reset();
    ambulance_move_dir = 2'(ML); ambulance_dest_x = 11'd300; ambulance_leftx = 11'd0;
    confirm();
    edge_(1, 0);
    chk("abort_onscene", int'(fsm_state), 3);
    repeat (2) edge_(1, 1);
    edge_(0, 1);
    chk("abort_state", int'(fsm_state), 5);
    chk("abort_siren", int'(siren_on), 0);
    chk("abort_no_clear", int'(clear_seen), 0);

    // Reset mid ON_SCENE.
    do_reset();
    confirm();
    edge_(1, 1);
    chk("rst_pre", int'(fsm_state), 3);
    reset = 1'b1;
    edge_(1, 1);
    reset = 1'b0;
    chk("rst_state", int'(fsm_state), 0);
    chk("rst_outs", int'({amb_visible, incident_active, siren_on, clear_scene, timeout_flag}), 0);
    chk("rst_count", int'(incident_count), 0);

    // Saturation: 257 complete incidents.
    do_reset();
    ambulance_move_dir = 2'(ML); ambulance_leftx = 11'd0;
    for (int n = 0; n < 257; n++) begin
      confirm();
      edge_(1, 0);
      repeat (DWELL) edge_(1, 1);
      edge_(0, 0);
      repeat (COOL) edge_(0, 1);
      if (n == 255) chk("sat_255", int'(incident_count), 255);
    end
    chk("sat_hold", int'(incident_count), 255);
    chk("sat_model", m_count, 255);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bit col;
      col = is_collision;
      if ($urandom_range(0, 7) == 0) col = !col;
      reset = ($urandom_range(0, 599) == 0);
      ambulance_move_dir = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        ambulance_dest_x = 11'($urandom_range(0, 2047));
        ambulance_dest_y = 10'($urandom_range(0, 1023));
        ambulance_width  = 11'($urandom_range(0, 300));
        ambulance_height = 10'($urandom_range(0, 300));
      end
      if ($urandom_range(0, 3) == 0) begin
        ambulance_leftx = 11'($urandom_range(0, 2047));
        ambulance_topy  = 10'($urandom_range(0, 1023));
      end
      edge_(col, ($urandom_range(0, 3) == 0));
    end
    reset = 1'b0;
    edge_(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
